// File: rtl/dac_serializer.sv
// rtl/dac_serializer.sv - one-sample buffered I2S-style serializer driving an external audio DAC
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   sample_in    unsigned mixed sample from the channel mixer
//   sample_valid sample_in valid
//   sample_ready holding buffer empty; a transfer happens on valid & ready
//   bclk         serial bit clock (2*CLK_DIV clk cycles per period)
//   lrclk        word select, 0 = left slot, 1 = right slot
//   sdata        serial data, MSB first, launched on the bclk falling edge
//   underrun     one-clk pulse when a frame starts with the buffer empty
module dac_serializer #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int SLOT_BITS    = 16,
    parameter int CLK_DIV      = 4,
    parameter int SIGNED_OUT   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    underrun
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_SIZE = BIT_W'(SLOT_BITS);

    localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    localparam logic [SAMPLE_WIDTH-1:0] MSB_FLIP = (SIGNED_OUT != 0) ? MIDSCALE : '0;

    logic [DIV_W-1:0]        div_cnt;
    logic                    bclk_q;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    lrclk_q;
    logic                    sdata_q;
    logic [SAMPLE_WIDTH-1:0] buf_data;
    logic                    buf_full;
    logic                    ready_q;
    logic [SAMPLE_WIDTH-1:0] frame_word;
    logic                    underrun_q;

    logic                    div_tc;
    logic                    bclk_fall;
    logic [BIT_W-1:0]        bit_next;
    logic                    frame_start;
    logic                    transfer;
    logic [BIT_W-1:0]        slot_idx;
    logic [SAMPLE_WIDTH-1:0] slot_shift;
    logic                    serial_bit;

    assign div_tc      = (div_cnt == DIV_LAST);
    assign bclk_fall   = div_tc & bclk_q;
    assign bit_next    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    assign frame_start = bclk_fall & (bit_cnt == BIT_LAST);
    assign transfer    = sample_valid & ready_q;

    // The 1-bit I2S delay means the bit launched for the new period b is
    // slot bit (b-1) mod SLOT_BITS, which is simply the old bit_cnt folded
    // into one slot.
    assign slot_idx = (bit_cnt >= SLOT_SIZE) ? bit_cnt - SLOT_SIZE : bit_cnt;

    // Shifting left by the slot index brings sample bit SAMPLE_WIDTH-1-k to
    // the MSB; indices past the sample width shift everything out, which
    // yields the zero padding bits for free.
    assign slot_shift = frame_word << slot_idx;
    assign serial_bit = slot_shift[SAMPLE_WIDTH-1];

    // Bit clock divider and frame position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bclk_q  <= 1'b0;
            bit_cnt <= BIT_LAST;
            lrclk_q <= 1'b1;
            sdata_q <= 1'b0;
        end else begin
            div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
            if (div_tc) begin
                bclk_q <= ~bclk_q;
            end
            if (bclk_fall) begin
                bit_cnt <= bit_next;
                lrclk_q <= (bit_next >= SLOT_SIZE);
                sdata_q <= serial_bit;
            end
        end
    end

    // Holding buffer, frame load and underrun reporting. The frame load
    // looks at buf_full from before this edge, so a sample arriving on the
    // frame-start edge of an empty buffer waits for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data   <= '0;
            buf_full   <= 1'b0;
            ready_q    <= 1'b1;
            frame_word <= MIDSCALE ^ MSB_FLIP;
            underrun_q <= 1'b0;
        end else begin
            if (transfer) begin
                buf_data <= sample_in;
            end
            buf_full <= transfer | (buf_full & ~frame_start);

            // Ready follows the buffer state one cycle late when it empties,
            // but drops on the transfer edge itself so a full buffer is
            // never offered again.
            ready_q <= ~buf_full & ~transfer;

            if (frame_start && buf_full) begin
                frame_word <= buf_data ^ MSB_FLIP;
            end
            underrun_q <= frame_start & ~buf_full;
        end
    end

    assign sample_ready = ready_q;
    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_dac_serializer.sv
// tb/tb_dac_serializer.sv - self-checking bench for dac_serializer (signed and unsigned instances)
module tb_dac_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sample_in = 8'h00;
    logic       sample_valid = 1'b0;

    logic sample_ready_s, bclk_s, lrclk_s, sdata_s, underrun_s;
    logic sample_ready_u, bclk_u, lrclk_u, sdata_u, underrun_u;

    always #5 clk = ~clk;

    dac_serializer #(.SAMPLE_WIDTH(8), .SLOT_BITS(16), .CLK_DIV(4), .SIGNED_OUT(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready_s), .bclk(bclk_s), .lrclk(lrclk_s),
        .sdata(sdata_s), .underrun(underrun_s)
    );

    dac_serializer #(.SAMPLE_WIDTH(8), .SLOT_BITS(16), .CLK_DIV(4), .SIGNED_OUT(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready_u), .bclk(bclk_u), .lrclk(lrclk_u),
        .sdata(sdata_u), .underrun(underrun_u)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int n_accept = 0;
    logic [7:0] src_q[$];
    logic rdy0, rdy1;

    typedef struct {
        string      name;
        bit         rst;
        int         pn;
        logic [7:0] p0, p1, p2;
        int         push_off;
        logic [7:0] pval;
        logic       under;
        logic [7:0] ws, wu;
        int         acc;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive();
        sample_valid = (src_q.size() > 0);
        sample_in    = (src_q.size() > 0) ? src_q[0] : 8'h00;
    endtask

    task automatic step();
        logic fire;
        fire = sample_valid && sample_ready_s;
        @(posedge clk);
        #1;
        cyc++;
        if (fire) begin
            void'(src_q.pop_front());
            n_accept++;
        end
        drive();
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src_q.delete();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        n_accept = 0;
    endtask

    // Entered just after a b=0 edge; runs one whole frame and stops just
    // after the next b=0 edge.
    task automatic check_frame(input string nm, input logic under, input logic [7:0] ws,
                               input logic [7:0] wu, input int push_off, input logic [7:0] pval);
        logic [31:0] cap_s, cap_u, cap_lr;
        logic cur_s, cur_u, cur_lr;
        int bclk_err, unstable, und_err;
        cap_s = '0; cap_u = '0; cap_lr = '0;
        cur_s = 1'b0; cur_u = 1'b0; cur_lr = 1'b0;
        bclk_err = 0; unstable = 0; und_err = 0;
        for (int o = 0; o < 256; o++) begin
            if (o % 8 == 0) begin
                cap_s  = {cap_s[30:0], sdata_s};
                cap_u  = {cap_u[30:0], sdata_u};
                cap_lr = {cap_lr[30:0], lrclk_s};
                cur_s = sdata_s; cur_u = sdata_u; cur_lr = lrclk_s;
            end else if (sdata_s !== cur_s || sdata_u !== cur_u || lrclk_s !== cur_lr) begin
                unstable++;
            end
            if (bclk_s !== ((o % 8) >= 4)) bclk_err++;
            if (underrun_s !== ((o == 0) ? under : 1'b0)) und_err++;
            if (underrun_u !== ((o == 0) ? under : 1'b0)) und_err++;
            if (o == 0) rdy0 = sample_ready_s;
            if (o == 1) rdy1 = sample_ready_s;
            if (o == push_off) begin
                src_q.push_back(pval);
                drive();
            end
            step();
        end
        chk({nm, " sdata signed"},   cap_s,  {1'b0, ws, 8'h00, ws, 7'h00});
        chk({nm, " sdata unsigned"}, cap_u,  {1'b0, wu, 8'h00, wu, 7'h00});
        chk({nm, " lrclk"},          cap_lr, 32'h0000_FFFF);
        chk({nm, " bclk errors"},    bclk_err, 0);
        chk({nm, " unstable bits"},  unstable, 0);
        chk({nm, " underrun errors"}, und_err, 0);
    endtask

    initial begin
        logic [7:0] tr_b, tr_l, tr_u;

        vt[0] = '{"idle0",  1'b1, 0, 8'h00, 8'h00, 8'h00, -1,  8'h00, 1'b1, 8'h00, 8'h80, 0};
        vt[1] = '{"idle1",  1'b0, 0, 8'h00, 8'h00, 8'h00, -1,  8'h00, 1'b1, 8'h00, 8'h80, 0};
        vt[2] = '{"strm10", 1'b1, 3, 8'h10, 8'h20, 8'h30, -1,  8'h00, 1'b0, 8'h90, 8'h10, 2};
        vt[3] = '{"strm20", 1'b0, 0, 8'h00, 8'h00, 8'h00, -1,  8'h00, 1'b0, 8'hA0, 8'h20, 3};
        vt[4] = '{"strm30", 1'b0, 0, 8'h00, 8'h00, 8'h00, -1,  8'h00, 1'b0, 8'hB0, 8'h30, 3};
        vt[5] = '{"strmend",1'b0, 0, 8'h00, 8'h00, 8'h00, -1,  8'h00, 1'b1, 8'hB0, 8'h30, 3};
        vt[6] = '{"s01",    1'b1, 1, 8'h01, 8'h00, 8'h00, -1,  8'h00, 1'b0, 8'h81, 8'h01, 1};
        vt[7] = '{"edge55a",1'b1, 0, 8'h00, 8'h00, 8'h00, 255, 8'h55, 1'b1, 8'h00, 8'h80, 1};
        vt[8] = '{"edge55b",1'b0, 0, 8'h00, 8'h00, 8'h00, -1,  8'h00, 1'b1, 8'h00, 8'h80, 1};
        vt[9] = '{"edge55c",1'b0, 0, 8'h00, 8'h00, 8'h00, -1,  8'h00, 1'b0, 8'hD5, 8'h55, 1};

        // Reset values and the first bclk/lrclk/underrun edges.
        do_reset();
        chk("reset bclk",     bclk_s, 1'b0);
        chk("reset lrclk",    lrclk_s, 1'b1);
        chk("reset sdata",    sdata_s, 1'b0);
        chk("reset ready",    sample_ready_s, 1'b1);
        chk("reset underrun", underrun_s, 1'b0);
        tr_b = '0; tr_l = '0; tr_u = '0;
        for (int c = 1; c <= 8; c++) begin
            step();
            tr_b = {tr_b[6:0], bclk_s};
            tr_l = {tr_l[6:0], lrclk_s};
            tr_u = {tr_u[6:0], underrun_s};
        end
        chk("bclk cycles 1..8",     tr_b, 8'b0001_1110);
        chk("lrclk cycles 1..8",    tr_l, 8'b1111_1110);
        chk("underrun cycles 1..8", tr_u, 8'b0000_0001);

        // Frame table.
        for (int i = 0; i < 10; i++) begin
            if (vt[i].rst) begin
                do_reset();
                if (vt[i].pn > 0) src_q.push_back(vt[i].p0);
                if (vt[i].pn > 1) src_q.push_back(vt[i].p1);
                if (vt[i].pn > 2) src_q.push_back(vt[i].p2);
                drive();
                step_to(8);
            end
            check_frame(vt[i].name, vt[i].under, vt[i].ws, vt[i].wu, vt[i].push_off, vt[i].pval);
            chk({vt[i].name, " accepted"}, n_accept, vt[i].acc);
        end

        // 8'hC3 offered during cycle 1: ready drops at 2, returns at 9.
        do_reset();
        step();
        chk("c3 ready cycle 1", sample_ready_s, 1'b1);
        src_q.push_back(8'hC3);
        drive();
        step();
        chk("c3 ready cycle 2", sample_ready_s, 1'b0);
        step_to(8);
        chk("c3 ready cycle 8", sample_ready_s, 1'b0);
        check_frame("c3", 1'b0, 8'h43, 8'hC3, -1, 8'h00);
        chk("c3 ready cycle 9", rdy1, 1'b1);
        chk("c3 accepted", n_accept, 1);

        // Asynchronous reset in the right slot with the buffer full.
        do_reset();
        src_q.push_back(8'hFF);
        src_q.push_back(8'h11);
        drive();
        step_to(157);
        chk("midrst pre bclk",  bclk_s, 1'b1);
        chk("midrst pre lrclk", lrclk_s, 1'b1);
        chk("midrst pre sdata", sdata_s, 1'b1);
        chk("midrst pre ready", sample_ready_s, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst bclk",  bclk_s, 1'b0);
        chk("midrst lrclk", lrclk_s, 1'b1);
        chk("midrst sdata", sdata_s, 1'b0);
        chk("midrst ready", sample_ready_s, 1'b1);
        do_reset();
        step_to(8);
        check_frame("after midrst", 1'b1, 8'h00, 8'h80, -1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
